// File: rtl/riscv_isa_pkg.sv
// riscv_isa: shared result payload type and physical-register index width.
package riscv_isa;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 6;
  typedef struct packed {
    logic [PREG_W-1:0] rd;
    logic              wr_en;
    logic [31:0]       data;
    logic [ROB_W-1:0]  rob_id;
  } result_t;
  localparam int RESULT_W = $bits(result_t);
endpackage

// File: rtl/writeback_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant; search starts at ptr, ptr moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            g;
  always_comb begin
    grant = '0;
    found = 1'b0;
    g     = 0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[(int'(ptr_q) + i) % N]) begin
        g        = (int'(ptr_q) + i) % N;
        grant[g] = 1'b1;
        found    = 1'b1;
      end
    end
    ptr_d = found ? PW'((g + 1) % N) : ptr_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: picks one unit result per cycle for regfile/ROB writeback and owns the register_valid scoreboard.
// Optional WB_BYPASS_EN: register_valid also reflects this cycle's granted destination.
module writeback_arbiter
  import riscv_isa::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int NUM_PREG  = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_UNITS-1:0]          result_valid,
  output logic [NUM_UNITS-1:0]          result_ready,
  input  logic [NUM_UNITS*RESULT_W-1:0] result_data,
  input  logic                          alloc_valid,
  input  logic [PREG_W-1:0]             alloc_addr,
  input  logic                          wb_ready,
  output logic                          rf_we,
  output logic [PREG_W-1:0]             rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic                          wb_valid,
  output logic [RESULT_W-1:0]           wb_data,
  output logic [NUM_PREG-1:0]           register_valid
);
  localparam logic [NUM_PREG-1:0] ONE = NUM_PREG'(1);
  result_t             sel, wb_q, wb_d;
  logic                wb_valid_q, grant_any, set_en, clr_en;
  logic [NUM_PREG-1:0] set_mask, clr_mask, sb_q, sb_d;
  // Gating with reset keeps result_ready low while reset is asserted.
  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (result_valid),
    .en    (wb_ready & reset),
    .grant (result_ready)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (result_ready[i]) sel = result_data[i*RESULT_W +: RESULT_W];
  end
  assign grant_any = |result_ready;
  assign set_en    = grant_any & sel.wr_en & (sel.rd != '0);
  assign clr_en    = alloc_valid & (alloc_addr != '0);
  assign set_mask  = set_en ? ONE << sel.rd : '0;
  assign clr_mask  = clr_en ? ONE << alloc_addr : '0;
  // A fresh allocation supersedes a stale writeback to the same preg.
  assign sb_d      = ((sb_q | set_mask) & ~clr_mask) | ONE;
  assign wb_d      = grant_any ? sel : wb_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      sb_q       <= '1;
    end else begin
      wb_valid_q <= grant_any;
      wb_q       <= wb_d;
      sb_q       <= sb_d;
    end
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_q;
  assign rf_we    = wb_valid_q & wb_q.wr_en & (wb_q.rd != '0);
  assign rf_waddr = wb_q.rd;
  assign rf_wdata = wb_q.data;
`ifdef WB_BYPASS_EN
  assign register_valid = sb_q | (set_mask & ~clr_mask);
`else
  assign register_valid = sb_q;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of grant order, latency, scoreboard and reset.
module tb_writeback_arbiter;
  import riscv_isa::*;
  localparam int NU = 4;
  localparam int NP = 128;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic                   clk = 1'b0;
  logic                   reset;
  logic [NU-1:0]          result_valid, result_ready;
  logic [NU*RESULT_W-1:0] result_data;
  logic                   alloc_valid, wb_ready, rf_we, wb_valid;
  logic [PREG_W-1:0]      alloc_addr, rf_waddr;
  logic [31:0]            rf_wdata;
  logic [RESULT_W-1:0]    wb_data;
  logic [NP-1:0]          register_valid;
  int tests = 0, errors = 0;

  writeback_arbiter #(.NUM_UNITS(NU), .NUM_PREG(NP)) dut (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .wb_ready(wb_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .register_valid(register_valid)
  );

  always #5 clk = ~clk;

  function automatic result_t mk(input int rd, input bit we, input logic [31:0] d, input int rob);
    result_t r;
    r.rd = PREG_W'(rd); r.wr_en = we; r.data = d; r.rob_id = ROB_W'(rob);
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_unit(input int u, input result_t r);
    result_data[u*RESULT_W +: RESULT_W] = r;
  endtask

  task automatic alloc(input int a);
    alloc_valid = 1'b1; alloc_addr = PREG_W'(a);
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (register_valid !== '1) begin errors++; $display("FAIL reset_sb got=%h exp=all ones", register_valid); end
    tests++; if (rf_we !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL reset_we got=%b%b exp=00", rf_we, wb_valid); end
    tests++; if (wb_data !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    tests++; if (result_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", result_ready); end
  endtask

  task automatic test_round_robin();
    int exp_u[5] = '{0, 1, 2, 3, 0};
    for (int u = 0; u < NU; u++) set_unit(u, mk(0, 1'b0, 32'h100 + u, u));
    result_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (result_ready !== 4'(1 << exp_u[k])) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, result_ready, 4'(1 << exp_u[k])); end
      step();
      tests++; if (wb_data !== mk(0, 1'b0, 32'h100 + exp_u[k], exp_u[k])) begin errors++; $display("FAIL rr_data%0d got=%h exp=%h", k, wb_data, mk(0, 1'b0, 32'h100 + exp_u[k], exp_u[k])); end
    end
  endtask

  task automatic test_stall();
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (result_ready !== '0) begin errors++; $display("FAIL stall_ready%0d got=%b exp=0000", k, result_ready); end
      step();
      tests++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_wbv%0d got=%b exp=0", k, wb_valid); end
    end
    wb_ready = 1'b1; #1;
    tests++; if (result_ready !== 4'b0010) begin errors++; $display("FAIL stall_release got=%b exp=0010", result_ready); end
    step();
    tests++; if (wb_valid !== 1'b1 || wb_data !== mk(0, 1'b0, 32'h101, 1)) begin errors++; $display("FAIL stall_data got=%h exp=%h", wb_data, mk(0, 1'b0, 32'h101, 1)); end
    result_valid = '0; #1;
    tests++; if (result_ready !== '0) begin errors++; $display("FAIL idle_ready got=%b exp=0000", result_ready); end
    step();
  endtask

  task automatic test_single();
    alloc(5);
    tests++; if (register_valid[5] !== 1'b0) begin errors++; $display("FAIL single_clr got=%b exp=0", register_valid[5]); end
    set_unit(2, mk(5, 1'b1, 32'hDEADBEEF, 3));
    result_valid = 4'b0100; #1;
    tests++; if (result_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", result_ready); end
    step();
    result_valid = '0;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 7'd5) begin errors++; $display("FAIL single_we got=%b/%0d exp=1/5", rf_we, rf_waddr); end
    tests++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got=%h exp=deadbeef", rf_wdata); end
    tests++; if (register_valid[5] !== 1'b1) begin errors++; $display("FAIL single_sb got=%b exp=1", register_valid[5]); end
    step();
    tests++; if (wb_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL single_drop got=%b%b exp=00", wb_valid, rf_we); end
  endtask

  task automatic test_collision();
    alloc(9);
    tests++; if (register_valid[9] !== 1'b0) begin errors++; $display("FAIL coll_clr got=%b exp=0", register_valid[9]); end
    set_unit(0, mk(9, 1'b1, 32'h99, 0));
    result_valid = 4'b0001; alloc_valid = 1'b1; alloc_addr = 7'd9; #1;
    tests++; if (register_valid[9] !== 1'b0) begin errors++; $display("FAIL coll_comb got=%b exp=0", register_valid[9]); end
    step();
    result_valid = '0; alloc_valid = 1'b0;
    tests++; if (register_valid[9] !== 1'b0 || rf_we !== 1'b1) begin errors++; $display("FAIL coll_sb got=%b/%b exp=0/1", register_valid[9], rf_we); end
  endtask

  task automatic test_x0_bypass();
    set_unit(1, mk(0, 1'b1, 32'h1234, 1));
    result_valid = 4'b0010;
    step();
    result_valid = '0;
    tests++; if (rf_we !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL x0_we got=%b/%b exp=0/1", rf_we, wb_valid); end
    tests++; if (register_valid[0] !== 1'b1) begin errors++; $display("FAIL x0_sb got=%b exp=1", register_valid[0]); end
    alloc(12);
    tests++; if (register_valid[12] !== 1'b0) begin errors++; $display("FAIL byp_clr got=%b exp=0", register_valid[12]); end
    set_unit(3, mk(12, 1'b1, 32'hC, 2));
    result_valid = 4'b1000; #1;
    tests++; if (register_valid[12] !== BYP) begin errors++; $display("FAIL byp_early got=%b exp=%b", register_valid[12], BYP); end
    step();
    result_valid = '0;
    tests++; if (register_valid[12] !== 1'b1) begin errors++; $display("FAIL byp_sb got=%b exp=1", register_valid[12]); end
  endtask

  task automatic test_async_reset();
    alloc(20);
    for (int u = 0; u < NU; u++) set_unit(u, mk(30 + u, 1'b1, 32'h200 + u, u));
    result_valid = '1;
    step();
    #2 reset = 1'b0; #1;
    tests++; if (register_valid !== '1) begin errors++; $display("FAIL areset_sb got=%h exp=all ones", register_valid); end
    tests++; if (rf_we !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL areset_we got=%b%b exp=00", rf_we, wb_valid); end
    tests++; if (result_ready !== '0) begin errors++; $display("FAIL areset_ready got=%b exp=0000", result_ready); end
    step();
    reset = 1'b1; #1;
    tests++; if (result_ready !== 4'b0001) begin errors++; $display("FAIL areset_ptr got=%b exp=0001", result_ready); end
    result_valid = '0;
    step();
  endtask

  initial begin
    reset = 1'b0; result_valid = '0; result_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0; wb_ready = 1'b1;
    step(); step();
    test_reset();
    reset = 1'b1;
    test_round_robin();
    test_stall();
    test_single();
    test_collision();
    test_x0_bypass();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
